// File: rtl/demux_pkg.sv
// Shared types and constants for the registered 1-to-8 demultiplexer / collector.
package demux_pkg;

    localparam int unsigned DEMUX_DEFAULT_WIDTH = 8;

    localparam logic MODE_ADDR = 1'b0;
    localparam logic MODE_AUTO = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        FILL = 2'b01,
        HOLD = 2'b10
    } demux_state_t;

endpackage : demux_pkg

// File: rtl/demux_ptr_ctr.sv
// Auto-fill bit pointer: increments with natural wrap, synchronous clear,
// and flags the last bit index so the FSM knows when a word completes.
module demux_ptr_ctr #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SEL_W = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [SEL_W-1:0] ptr_o,
    output logic             last_o
);

    logic [SEL_W-1:0] ptr_q;
    logic [SEL_W-1:0] ptr_d;

    // Next pointer: clear wins over increment; WIDTH is a power of two so +1 wraps.
    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = ptr_q + SEL_W'(1);
        end
    end

    // Pointer register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o  = ptr_q;
    assign last_o = (ptr_q == SEL_W'(WIDTH - 1));

endmodule : demux_ptr_ctr

// File: rtl/demux1_8_seq.sv
// Registered 1-to-8 demultiplexer and serial-to-parallel collector.
// Addressed mode writes IN to Output[Sel]; auto mode fills bits in order and
// presents the finished word with a Word_valid/Word_ready handshake.
// Optional feature macro: DEMUX1_8_TRISTATE_EN (Output floats while disabled or in reset).
module demux1_8_seq
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = DEMUX_DEFAULT_WIDTH,
    parameter int unsigned SEL_W = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             ENA,
    input  logic             Mode,
    input  logic             IN,
    input  logic             IN_valid,
    output logic             IN_ready,
    input  logic [SEL_W-1:0] Sel,
    output logic [WIDTH-1:0] Output,
    output logic             Word_valid,
    input  logic             Word_ready,
    output logic [SEL_W-1:0] Ptr
);

    demux_state_t     state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             wv_q, wv_d;

    logic             accept;
    logic             ptr_clr;
    logic             ptr_inc;
    logic             ptr_last;
    logic [SEL_W-1:0] ptr;

    demux_ptr_ctr #(
        .WIDTH (WIDTH),
        .SEL_W (SEL_W)
    ) u_ptr (
        .clk_i  (CLK),
        .rst_ni (RST_N),
        .clr_i  (ptr_clr),
        .inc_i  (ptr_inc),
        .ptr_o  (ptr),
        .last_o (ptr_last)
    );

    // Ready is gated by reset and enable so a disabled block never accepts.
    assign IN_ready = RST_N && ENA && (state_q != HOLD);
    assign accept   = IN_valid && IN_ready;

    // Next-state, data steering and pointer control.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        wv_d    = wv_q;
        ptr_clr = 1'b0;
        ptr_inc = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (Mode == MODE_AUTO) begin
                        out_d[0] = IN;
                        ptr_inc  = 1'b1;
                        state_d  = FILL;
                    end else begin
                        out_d[Sel] = IN;
                    end
                end
            end
            FILL: begin
                if (accept) begin
                    out_d[ptr] = IN;
                    ptr_inc    = 1'b1;
                    if (ptr_last) begin
                        state_d = HOLD;
                        wv_d    = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (ENA && Word_ready) begin
                    state_d = IDLE;
                    wv_d    = 1'b0;
                    ptr_clr = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                wv_d    = 1'b0;
                ptr_clr = 1'b1;
            end
        endcase
    end

    // State, data and word-valid registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
            out_q   <= '0;
            wv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            wv_q    <= wv_d;
        end
    end

    // The completed-word flag survives a disable but is hidden while ENA is low.
    assign Word_valid = wv_q && ENA;
    assign Ptr        = ptr;

`ifdef DEMUX1_8_TRISTATE_EN
    assign Output = (ENA && RST_N) ? out_q : {WIDTH{1'bz}};
`else
    assign Output = out_q;
`endif

endmodule : demux1_8_seq

// File: tb/tb_demux1_8_seq.sv
// Directed self-checking bench for demux1_8_seq (8-bit default build).
module tb_demux1_8_seq;

    logic       CLK;
    logic       RST_N;
    logic       ENA;
    logic       Mode;
    logic       IN;
    logic       IN_valid;
    logic       IN_ready;
    logic [2:0] Sel;
    logic [7:0] Output;
    logic       Word_valid;
    logic       Word_ready;
    logic [2:0] Ptr;

    int checks = 0;
    int errors = 0;

`ifdef DEMUX1_8_TRISTATE_EN
    localparam bit TRI_EN = 1'b1;
`else
    localparam bit TRI_EN = 1'b0;
`endif

    demux1_8_seq dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .ENA        (ENA),
        .Mode       (Mode),
        .IN         (IN),
        .IN_valid   (IN_valid),
        .IN_ready   (IN_ready),
        .Sel        (Sel),
        .Output     (Output),
        .Word_valid (Word_valid),
        .Word_ready (Word_ready),
        .Ptr        (Ptr)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected Output when the block is disabled or in reset.
    function automatic logic [7:0] gated(input logic [7:0] v);
        return TRI_EN ? 8'bzzzz_zzzz : v;
    endfunction

    initial begin
        RST_N = 1'b0; ENA = 1'b1; Mode = 1'b0; IN = 1'b1; IN_valid = 1'b1;
        Sel = 3'd0; Word_ready = 1'b0;

        // Reset with IN_valid high
        tick(); tick();
        chk("rst_output", 32'(Output), 32'(gated(8'h00)));
        chk("rst_ptr", 32'(Ptr), 32'd0);
        chk("rst_wvalid", 32'(Word_valid), 32'd0);
        chk("rst_inready", 32'(IN_ready), 32'd0);

        RST_N = 1'b1; IN_valid = 1'b0;
        tick();
        chk("idle_inready", 32'(IN_ready), 32'd1);
        chk("idle_output", 32'(Output), 32'h00);

        // Addressed writes to odd bits
        IN_valid = 1'b1; IN = 1'b1;
        for (int s = 1; s < 8; s += 2) begin
            Sel = 3'(s);
            tick();
        end
        chk("addr_aa", 32'(Output), 32'hAA);
        Sel = 3'd3; IN = 1'b0;
        tick();
        chk("addr_a2", 32'(Output), 32'hA2);
        chk("addr_wvalid", 32'(Word_valid), 32'd0);
        chk("addr_ptr", 32'(Ptr), 32'd0);
        IN_valid = 1'b0; IN = 1'b1; Sel = 3'd0;
        tick();
        chk("addr_novalid", 32'(Output), 32'hA2);

        // Auto fill 0,1,0,1,... LSB first
        Mode = 1'b1; IN_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            IN = 1'(i & 1);
            tick();
            if (i == 3) chk("auto_ptr4", 32'(Ptr), 32'd4);
        end
        chk("auto_output", 32'(Output), 32'hAA);
        chk("auto_wvalid", 32'(Word_valid), 32'd1);
        chk("auto_inready", 32'(IN_ready), 32'd0);
        chk("auto_ptr_wrap", 32'(Ptr), 32'd0);

        // Hold without Word_ready; IN traffic must be ignored
        IN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_wvalid", 32'(Word_valid), 32'd1);
            chk("hold_output", 32'(Output), 32'hAA);
        end

        // Handshake with IN_valid also high: no write that cycle
        Word_ready = 1'b1;
        tick();
        Word_ready = 1'b0;
        chk("hs_wvalid", 32'(Word_valid), 32'd0);
        chk("hs_nowrite", 32'(Output), 32'hAA);
        chk("hs_inready", 32'(IN_ready), 32'd1);
        tick();
        chk("hs_newword", 32'(Output), 32'hAB);
        chk("hs_newptr", 32'(Ptr), 32'd1);

        // Three more ones, then freeze at Ptr=4
        for (int i = 0; i < 3; i++) tick();
        chk("frz_pre_ptr", 32'(Ptr), 32'd4);
        chk("frz_pre_out", 32'(Output), 32'hAF);
        ENA = 1'b0;
        tick(); tick();
        chk("frz_ptr", 32'(Ptr), 32'd4);
        chk("frz_output", 32'(Output), 32'(gated(8'hAF)));
        chk("frz_inready", 32'(IN_ready), 32'd0);
        ENA = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("frz_done_out", 32'(Output), 32'hFF);
        chk("frz_done_wv", 32'(Word_valid), 32'd1);

        // Word_ready ignored and Word_valid masked while disabled
        ENA = 1'b0; Word_ready = 1'b1;
        tick();
        chk("mask_wvalid", 32'(Word_valid), 32'd0);
        ENA = 1'b1; Word_ready = 1'b0;
        tick();
        chk("mask_restored", 32'(Word_valid), 32'd1);
        Word_ready = 1'b1; IN_valid = 1'b0;
        tick();
        Word_ready = 1'b0;
        chk("mask_hs", 32'(Word_valid), 32'd0);

        // Mode dropped during FILL: fill continues, Sel ignored
        Mode = 1'b1; IN_valid = 1'b1; IN = 1'b1;
        tick();
        Mode = 1'b0; Sel = 3'd2;
        for (int i = 1; i < 8; i++) begin
            IN = (i == 7);
            tick();
        end
        chk("modetog_out", 32'(Output), 32'h81);
        chk("modetog_wv", 32'(Word_valid), 32'd1);
        Word_ready = 1'b1; IN_valid = 1'b0;
        tick();
        Word_ready = 1'b0;

        // Reset mid-word at Ptr=6
        Mode = 1'b1; IN_valid = 1'b1; IN = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        chk("midrst_ptr6", 32'(Ptr), 32'd6);
        chk("midrst_pre", 32'(Output), 32'hBF);
        RST_N = 1'b0;
        tick();
        chk("midrst_out", 32'(Output), 32'(gated(8'h00)));
        chk("midrst_ptr", 32'(Ptr), 32'd0);
        RST_N = 1'b1; IN_valid = 1'b0;
        tick();
        chk("postrst_out", 32'(Output), 32'h00);
        chk("postrst_wv", 32'(Word_valid), 32'd0);
        Mode = 1'b0; Sel = 3'd5; IN = 1'b1; IN_valid = 1'b1;
        tick();
        chk("postrst_idle", 32'(Output), 32'h20);
        chk("postrst_ptr", 32'(Ptr), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_demux1_8_seq

// File: doc/demux1_8_seq.md
# demux1_8_seq

Registered 1-to-8 demultiplexer and serial-to-parallel collector; the receive-side counterpart of the 8:1 enabled mux. It takes one serial bit per handshake and steers it into an 8-bit parallel register. In addressed mode, the caller's `Sel` chooses the target bit. In auto mode, an internal pointer fills the bits in order and presents a completed word with a valid/ready handshake. It sits downstream of the mux path wherever a serialized bit stream must be rebuilt into a parallel word.

## Interface
- `WIDTH`, default 8: parallel word width; must be a power of two and at least 2.
- `SEL_W`, default `$clog2(WIDTH)`: width of `Sel` and `Ptr`.

Ports:
- `CLK` in 1: single clock; all state updates on the rising edge.
- `RST_N` in 1: reset, synchronous and active-low.
- `ENA` in 1: block enable; low freezes all state.
- `Mode` in 1: 0 = addressed, 1 = auto. Sampled only in IDLE.
- `IN` in 1: serial data bit.
- `IN_valid` in 1: `IN` is valid this cycle.
- `IN_ready` out 1: block can accept a bit this cycle.
- `Sel` in `SEL_W`: target bit index (addressed mode only).
- `Output` out `WIDTH`: parallel data register.
- `Word_valid` out 1: complete auto-mode word is available.
- `Word_ready` in 1: consumer accepts the word.
- `Ptr` out `SEL_W`: current auto-fill index.

## Operation
- **Accept rule:** a bit is accepted when `IN_valid && IN_ready` at a rising edge.
- **`IN_ready`:** equals `RST_N && ENA && (state != HOLD)`.
- **States:** IDLE, FILL, HOLD.
- **IDLE, `Mode`=0 (addressed):**
  - Accept → `Output[Sel] <= IN`; all other bits hold.
  - State stays IDLE; `Word_valid` stays 0; `Ptr` unchanged.
- **IDLE, `Mode`=1 (auto):**
  - Accept → `Output[0] <= IN`, `Ptr <= 1`, state → FILL.
- **FILL:**
  - Each accept → `Output[Ptr] <= IN`, `Ptr <= Ptr+1`.
  - Accept at `Ptr == WIDTH-1` → `Ptr` wraps to 0, state → HOLD, `Word_valid <= 1`.
  - `Mode` and `Sel` are ignored.
- **HOLD:**
  - `IN_ready`=0; `Output` is stable.
  - `Word_ready`=1 (with `ENA`=1) → state → IDLE, `Word_valid <= 0`.
- **`ENA`=0:**
  - No accepts; state, `Ptr` and `Output` are frozen.
  - `Word_ready` is ignored.
  - `Word_valid` output is masked to 0; the internal flag is kept and reappears when `ENA` returns.
- **Mode change outside IDLE:** has no effect until the block returns to IDLE.
- **Reset mid-word:** the partial word is discarded; all registers take reset values at the edge.
- **Reset values:** `Output`=0, `Ptr`=0, state=IDLE, `Word_valid`=0, `IN_ready`=0 while `RST_N`=0.

## Timing
- `Output`, `Ptr`, `Word_valid` and state are registered. `IN_ready` is combinational from state, `ENA` and `RST_N`.
- **Write latency:** a bit accepted at edge N is visible on `Output` after edge N.
- **Auto-mode word:** `Word_valid` rises after the edge of the WIDTH-th accept.
- **Best-case throughput:** one word per WIDTH+1 cycles (WIDTH accepts plus one HOLD cycle with `Word_ready`=1).
- **HOLD duration:** `Word_valid` stays high for every HOLD cycle until the handshake. It falls on the edge where `Word_ready`=1 is sampled.
- **New word after handshake:** no bit is accepted in that same cycle; the next word can start on the following cycle.

## Configuration
- **`DEMUX1_8_TRISTATE_EN` defined:**
  - `Output` is driven `'z` on every bit while `ENA`=0; the internal register is kept.
  - `Output` is also `'z` during reset cycles.
- **Undefined:** `Output` always drives the internal register value, including while `ENA`=0.

## Structure
- **Package `demux_pkg`:**
  - state typedef `demux_state_t` with IDLE=2'b00, FILL=2'b01, HOLD=2'b10;
  - `MODE_ADDR`=1'b0 and `MODE_AUTO`=1'b1;
  - `DEMUX_DEFAULT_WIDTH`=8.
- **Sub-module `demux_ptr_ctr`:** `SEL_W`-bit pointer with increment, wrap and synchronous clear; it flags last index (`Ptr == WIDTH-1`) for the FSM.
- **Top level:** holds the FSM, the output register, and the tristate gating under the macro.

## Test plan
- **Reset:** hold `RST_N`=0 for 2 cycles with `IN_valid`=1 → `Output`=8'h00, `Ptr`=0, `Word_valid`=0, `IN_ready`=0.
- **Addressed mode:**
  - `Mode`=0, `ENA`=1; write `IN`=1 at `Sel`=1, 3, 5, 7 → `Output`=8'hAA.
  - Then `Sel`=3, `IN`=0 → `Output`=8'hA2; `Word_valid` never rises.
- **Auto mode:**
  - `Mode`=1; stream bits 0,1,0,1,0,1,0,1 (LSB first) → after the 8th accept, `Output`=8'hAA, `Word_valid`=1, `IN_ready`=0, `Ptr`=0.
  - Hold `Word_ready`=0 for 3 cycles → `Word_valid` stays 1 and `Output` is stable.
- **Handshake boundary:** in HOLD, assert `Word_ready`=1 and `IN_valid`=1 together → IDLE next cycle and no bit written that cycle; a new word starts the following cycle.
- **Enable freeze:** drop `ENA` after 4 auto bits of 8'hFF → `Ptr`=4 is held and `Output` is `'z` with the macro. Restore `ENA` and send 4 more ones → `Output`=8'hFF, `Word_valid`=1.
- **Corner cases:**
  - Reset asserted at `Ptr`=6 → state IDLE, `Output`=0 next cycle.
  - `Mode` toggled to 0 during FILL → fill continues to completion.
